spi_sclk_gen: RTL and testbench

//  Parametrised SPI serial-clock generator for the SPI master datapath; successor to the fixed divide-by-8, CPOL=1, 8-bit generator.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_halfper_cnt.sv | 36 +++
 rtl/spi_sclk_gen.sv | 196 +++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI serial-clock generator.
// Imported by the half-period counter and the top.
package spi_pkg;

  localparam int SPI_DIV_W = 8;
  localparam int SPI_CNT_W = 6;

  localparam logic CPHA_LEAD_SAMPLE = 1'b0;
  localparam logic CPHA_LEAD_SHIFT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GUARD = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_halfper_cnt.sv
// Half-period counter: clear beats enable, terminal flag when
// the count equals the latched divider.
module spi_halfper_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK generator: runtime divider, CPOL/CPHA, bit count,
// lead/trail strobes and mode-resolved sample/shift enables.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int   DIV_W    = SPI_DIV_W,
  parameter int   CNT_W    = SPI_CNT_W,
  parameter logic SCLK_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] num_bits,
  output logic             sclk,
  output logic             lead_edge,
  output logic             trail_edge,
  output logic             sample_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  spi_state_e       state_q, state_d;
  logic             sclk_q, sclk_d;
  logic             lead_q, lead_d;
  logic             trail_q, trail_d;
  logic             samp_q, samp_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;

  logic cnt_clr;
  logic cnt_en;
  logic tc;
  logic last_bit;

  spi_halfper_cnt #(
    .W(DIV_W)
  ) u_hp (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .term_i(div_q),
    .tc_o  (tc)
  );

  assign last_bit = ((bits_q + CNT_W'(1)) == nbits_q);

  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    lead_d  = 1'b0;
    trail_d = 1'b0;
    samp_d  = 1'b0;
    shift_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    phase_d = phase_q;
    bits_d  = bits_q;
    nbits_d = nbits_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = cpol_q;
        if (start && (num_bits != '0)) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          div_d   = div;
          nbits_d = num_bits;
          bits_d  = '0;
          phase_d = 1'b0;
          cnt_clr = 1'b1;
          sclk_d  = cpol;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (tc) begin
          cnt_clr = 1'b1;
          sclk_d  = ~sclk_q;
          phase_d = ~phase_q;
          if (!phase_q) begin
            lead_d = 1'b1;
            if (cpha_q == CPHA_LEAD_SAMPLE) begin
              samp_d = 1'b1;
            end else begin
              shift_d = 1'b1;
            end
          end else begin
            trail_d = 1'b1;
            bits_d  = bits_q + CNT_W'(1);
            if (cpha_q == CPHA_LEAD_SAMPLE) begin
              shift_d = ~last_bit;
            end else begin
              samp_d = 1'b1;
            end
            if (last_bit) begin
              state_d = ST_GUARD;
            end
          end
        end
      end
      ST_GUARD: begin
        cnt_en = 1'b1;
        if (tc) begin
          cnt_clr = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over everything, including a same-cycle start.
    if (abort) begin
      state_d = ST_IDLE;
      sclk_d  = cpol_q;
      lead_d  = 1'b0;
      trail_d = 1'b0;
      samp_d  = 1'b0;
      shift_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      div_d   = div_q;
      nbits_d = nbits_q;
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sclk_q  <= SCLK_RST;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      samp_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      phase_q <= 1'b0;
      bits_q  <= '0;
      nbits_q <= '0;
      div_q   <= '0;
      cpol_q  <= SCLK_RST;
      cpha_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      lead_q  <= lead_d;
      trail_q <= trail_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      phase_q <= phase_d;
      bits_q  <= bits_d;
      nbits_q <= nbits_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
    end
  end

  assign sclk       = sclk_q;
  assign lead_edge  = lead_q;
  assign trail_edge = trail_q;
  assign sample_en  = samp_q;
  assign shift_en   = shift_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen: reset, all edge/strobe counts,
// spacing, abort and mid-transfer disturbance.
module tb_spi_sclk_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       cpol;
  logic       cpha;
  logic [7:0] div;
  logic [5:0] num_bits;
  logic       sclk;
  logic       lead_edge;
  logic       trail_edge;
  logic       sample_en;
  logic       shift_en;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  spi_sclk_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cpol      (cpol),
    .cpha      (cpha),
    .div       (div),
    .num_bits  (num_bits),
    .sclk      (sclk),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .sample_en (sample_en),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic run_xfer(
    input string tag,
    input logic  pol,
    input logic  pha,
    input int    d,
    input int    nb,
    input int    exp_busy,
    input int    exp_tog,
    input int    exp_samp,
    input int    exp_shift,
    input bit    disturb
  );
    int   nbusy, ntog, nlead, ntrail, nsamp, nshift, ndone;
    int   errsp, erredge, errboth, errlvl, errdone, last;
    logic prev;
    logic tog;
    nbusy = 0; ntog = 0; nlead = 0; ntrail = 0; nsamp = 0;
    nshift = 0; ndone = 0; errsp = 0; erredge = 0; errboth = 0;
    errlvl = 0; errdone = 0; last = 1;
    @(negedge clk);
    cpol = pol; cpha = pha; div = 8'(d); num_bits = 6'(nb); start = 1'b1;
    prev = pol;
    for (int i = 1; i <= 2000 && ndone == 0; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (disturb && i == 5) begin
        start = 1'b1; div = ~div; cpol = ~cpol; num_bits = 6'd3;
      end
      if (disturb && i == 6) start = 1'b0;
      tog = (sclk !== prev);
      if (busy) nbusy++;
      if (tog) begin
        ntog++;
        if (i - last != d + 1) errsp++;
        last = i;
      end
      if ((lead_edge || trail_edge) != tog) erredge++;
      if (lead_edge && trail_edge) errboth++;
      if (lead_edge) nlead++;
      if (trail_edge) ntrail++;
      if (shift_en) nshift++;
      if (sample_en) begin
        nsamp++;
        if (sclk !== ~(pol ^ pha)) errlvl++;
      end
      if (done) begin
        ndone++;
        if (busy) errdone++;
      end
      prev = sclk;
    end
    cpol = pol; div = 8'(d); num_bits = 6'(nb);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk({tag, ".busy"}, nbusy, exp_busy);
    chk({tag, ".tog"}, ntog, exp_tog);
    chk({tag, ".lead"}, nlead, exp_tog / 2);
    chk({tag, ".trail"}, ntrail, exp_tog / 2);
    chk({tag, ".samp"}, nsamp, exp_samp);
    chk({tag, ".shift"}, nshift, exp_shift);
    chk({tag, ".done"}, ndone, 1);
    chk({tag, ".spacing"}, errsp, 0);
    chk({tag, ".edge"}, erredge, 0);
    chk({tag, ".both"}, errboth, 0);
    chk({tag, ".lvl"}, errlvl, 0);
    chk({tag, ".donebusy"}, errdone, 0);
    chk({tag, ".idle"}, int'(sclk), int'(pol));
  endtask

  initial begin
    int nb_busy, nb_done;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cpol = 1'b0; cpha = 1'b0; div = 8'd1; num_bits = 6'd8;
    repeat (3) @(negedge clk);
    chk("rst.sclk", int'(sclk), 1);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.strb", int'({lead_edge, trail_edge, sample_en, shift_en}), 0);
    rst = 1'b1;

    // reset asserted in the middle of a transfer
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst.sclk", int'(sclk), 1);
    chk("mrst.busy", int'(busy), 0);
    chk("mrst.strb", int'({lead_edge, trail_edge, sample_en, shift_en}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nb_busy = 0; nb_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb_busy++;
      if (done) nb_done++;
    end
    chk("mrst.nobusy", nb_busy, 0);
    chk("mrst.nodone", nb_done, 0);

    run_xfer("m0", 1'b0, 1'b0, 1, 8, 34, 16, 8, 7, 1'b0);
    run_xfer("m3", 1'b1, 1'b1, 3, 4, 36, 8, 4, 4, 1'b0);
    run_xfer("d0", 1'b0, 1'b0, 0, 1, 3, 2, 1, 0, 1'b0);

    // zero-length request is ignored
    @(negedge clk);
    num_bits = 6'd0; start = 1'b1;
    nb_busy = 0; nb_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nb_busy++;
      if (done) nb_done++;
    end
    chk("z.busy", nb_busy, 0);
    chk("z.done", nb_done, 0);

    run_xfer("dist", 1'b0, 1'b0, 1, 8, 34, 16, 8, 7, 1'b1);

    // abort on cycle 10 of a mode-1 transfer
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b1; div = 8'd2; num_bits = 6'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab.busy", int'(busy), 0);
    chk("ab.sclk", int'(sclk), 0);
    chk("ab.strb", int'({lead_edge, trail_edge, sample_en, shift_en}), 0);
    chk("ab.done", int'(done), 0);
    nb_busy = 0; nb_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) nb_busy++;
      if (done) nb_done++;
    end
    chk("ab.nobusy", nb_busy, 0);
    chk("ab.nodone", nb_done, 0);

    run_xfer("m1", 1'b0, 1'b1, 2, 8, 51, 16, 8, 8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
